seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_ctrl_pkg.sv | 45 ++++
 rtl/seg_display_ctrl_bin2bcd.sv | 82 ++++++++
 rtl/seg_display_ctrl.sv | 129 ++++++++++++
 tb/tb_seg_display_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants for the signed-product 7-segment display controller:
// segment patterns, BCD geometry and the converter state encoding.
package seg_display_ctrl_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int NUM_DIGITS  = 5;
  localparam int BCD_W       = BCD_DIGIT_W * NUM_DIGITS;
  localparam int MAG_W       = 17;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } conv_state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd.sv
// Sequential double-dabble converter: 17-bit magnitude to five BCD digits,
// one bit per cycle; bcd only changes on the final step of a conversion.
module bin2bcd
  import seg_display_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             finish
);

  conv_state_e        state_r;
  logic [3:0]         cnt_r;
  logic [MAG_W-2:0]   shift_r;
  logic [BCD_W-1:0]   acc_r;
  logic [BCD_W-1:0]   bcd_r;
  logic               busy_r;
  logic [BCD_W-1:0]   adj_s;
  logic [BCD_W-1:0]   acc_nxt_s;
  logic               last_s;

  // Add-3 correction on every digit that would overflow past 9 when doubled
  always_comb begin
    adj_s = acc_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_r[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
        adj_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] = acc_r[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end else begin
        adj_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] = acc_r[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  assign acc_nxt_s = {adj_s[BCD_W-2:0], shift_r[MAG_W-2]};
  assign last_s    = (state_r == ST_SHIFT) && (cnt_r == 4'd15);

  // Converter FSM; bin[16] is preloaded into acc so 16 steps cover all 17 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      shift_r <= '0;
      acc_r   <= '0;
      bcd_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_SHIFT;
            cnt_r   <= 4'd0;
            shift_r <= bin[MAG_W-2:0];
            acc_r   <= {{(BCD_W-1){1'b0}}, bin[MAG_W-1]};
            busy_r  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          acc_r   <= acc_nxt_s;
          shift_r <= {shift_r[MAG_W-3:0], 1'b0};
          cnt_r   <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            bcd_r   <= acc_nxt_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd    = bcd_r;
  assign busy   = busy_r;
  assign finish = last_s;

endmodule

// File: rtl/seg_display_ctrl.sv
// Captures a signed multiplier product on the rising edge of done, converts it
// to BCD and multiplexes sign plus a 3-digit window onto a 4-digit display.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int CNT_MAX = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] product,
  input  logic        done,
  input  logic        win_hi,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic             done_q_r;
  logic             armed_r;
  logic             sign_pend_r;
  logic             sign_disp_r;
  logic [CNT_W-1:0] ref_cnt_r;
  logic [1:0]       idx_r;
  logic [6:0]       seg_r;
  logic [3:0]       an_r;
  logic             capture_s;
  logic             start_s;
  logic             conv_busy_s;
  logic             conv_last_s;
  logic [MAG_W-1:0] prod_ext_s;
  logic [MAG_W-1:0] mag_s;
  logic [BCD_W-1:0] bcd_s;
  logic [6:0]       seg_nxt_s;
  logic [3:0]       an_nxt_s;

  // armed_r blocks a capture from a done level that was already high at reset
  assign capture_s  = done && !done_q_r && armed_r;
  assign start_s    = capture_s && !conv_busy_s;
  assign prod_ext_s = {product[15], product};
  assign mag_s      = product[15] ? (~prod_ext_s + 17'd1) : prod_ext_s;

  bin2bcd u_bin2bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_s),
    .bin    (mag_s),
    .bcd    (bcd_s),
    .busy   (conv_busy_s),
    .finish (conv_last_s)
  );

  // Edge detection and sign bookkeeping; displayed sign moves with the digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q_r    <= 1'b0;
      armed_r     <= ~done;
      sign_pend_r <= 1'b0;
      sign_disp_r <= 1'b0;
    end else begin
      done_q_r <= done;
      armed_r  <= armed_r | ~done;
      if (start_s) begin
        sign_pend_r <= product[15];
      end
      if (conv_last_s) begin
        sign_disp_r <= sign_pend_r;
      end
    end
  end

  // Refresh timer and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt_r <= '0;
      idx_r     <= 2'd0;
    end else if (ref_cnt_r == CNT_W'(CNT_MAX - 1)) begin
      ref_cnt_r <= '0;
      idx_r     <= idx_r + 2'd1;
    end else begin
      ref_cnt_r <= ref_cnt_r + CNT_W'(1);
    end
  end

  // Digit selection for the current index and window
  always_comb begin
    seg_nxt_s = SEG_BLANK;
    an_nxt_s  = 4'b1110;
    case (idx_r)
      2'd0: begin
        an_nxt_s  = 4'b1110;
        seg_nxt_s = win_hi ? seg_of(bcd_s[15:12]) : seg_of(bcd_s[3:0]);
      end
      2'd1: begin
        an_nxt_s  = 4'b1101;
        seg_nxt_s = win_hi ? seg_of(bcd_s[19:16]) : seg_of(bcd_s[7:4]);
      end
      2'd2: begin
        an_nxt_s  = 4'b1011;
        seg_nxt_s = win_hi ? SEG_BLANK : seg_of(bcd_s[11:8]);
      end
      2'd3: begin
        an_nxt_s  = 4'b0111;
        seg_nxt_s = sign_disp_r ? SEG_MINUS : SEG_BLANK;
      end
      default: begin
        an_nxt_s  = 4'b1110;
        seg_nxt_s = SEG_BLANK;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r <= SEG_0;
      an_r  <= 4'b1110;
    end else begin
      seg_r <= seg_nxt_s;
      an_r  <= an_nxt_s;
    end
  end

  assign seg  = seg_r;
  assign an   = an_r;
  assign busy = conv_busy_s;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed scenarios plus random
// products, checked against a decimal-arithmetic model of the display.
module tb_seg_display_ctrl;

  localparam int CNT_MAX = 4;
  localparam int ROT     = 4 * CNT_MAX;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] product;
  logic        done;
  logic        win_hi;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // model of what the display registers should hold
  bit model_neg = 1'b0;
  int model_mag = 0;

  always #5 clk = ~clk;

  seg_display_ctrl #(.CNT_MAX(CNT_MAX)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .product (product),
    .done    (done),
    .win_hi  (win_hi),
    .seg     (seg),
    .an      (an),
    .busy    (busy)
  );

  function automatic logic [6:0] dig_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input bit win, input bit neg, input int mag);
    int dg[5];
    int m;
    m = mag;
    for (int i = 0; i < 5; i++) begin
      dg[i] = m % 10;
      m = m / 10;
    end
    case (idx)
      3: return neg ? 7'b0111111 : 7'b1111111;
      2: return win ? 7'b1111111 : dig_pat(dg[2]);
      1: return win ? dig_pat(dg[4]) : dig_pat(dg[1]);
      default: return win ? dig_pat(dg[3]) : dig_pat(dg[0]);
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    case (idx)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic void set_model(input int v);
    model_neg = (v < 0);
    model_mag = (v < 0) ? -v : v;
  endfunction

  task automatic start_conv(input int v);
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    product = 16'(v);
    done = 1'b1;
  endtask

  task automatic count_busy(output int c);
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) c++;
      else break;
    end
  endtask

  // selects a window, lets it settle, then records one full refresh rotation
  task automatic observe(input bit win, output logic [3:0][6:0] obs, output int bad_an);
    @(negedge clk);
    win_hi = win;
    obs = 'x;
    bad_an = 0;
    repeat (2 * ROT) @(negedge clk);
    for (int s = 0; s < ROT; s++) begin
      @(negedge clk);
      case (an)
        4'b1110: obs[0] = seg;
        4'b1101: obs[1] = seg;
        4'b1011: obs[2] = seg;
        4'b0111: obs[3] = seg;
        default: bad_an++;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; done = 1'b0; product = 16'd0; win_hi = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (an !== 4'b1110) $display("FAIL reset_an got %b want 1110", an); else n_pass++;
    n_checks++; if (seg !== 7'b1000000) $display("FAIL reset_seg got %b want 1000000", seg); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    rst_n = 1'b1;
    set_model(0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an(((k - 1) / CNT_MAX) % 4))
        $display("FAIL rotate_an k=%0d got %b want %b", k, an, exp_an(((k - 1) / CNT_MAX) % 4));
      else n_pass++;
    end
  endtask

  task automatic test_directed(input int v);
    int c, bad;
    logic [3:0][6:0] obs;
    start_conv(v);
    count_busy(c);
    set_model(v);
    n_checks++; if (c !== 16) $display("FAIL busy_len v=%0d got %0d want 16", v, c); else n_pass++;
    for (int w = 0; w < 2; w++) begin
      observe(w[0], obs, bad);
      n_checks++; if (bad !== 0) $display("FAIL an_onehot v=%0d got %0d bad want 0", v, bad); else n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs[k] !== exp_seg(k, w[0], model_neg, model_mag))
          $display("FAIL digit v=%0d win=%0d idx=%0d got %b want %b", v, w, k, obs[k], exp_seg(k, w[0], model_neg, model_mag));
        else n_pass++;
      end
    end
  endtask

  task automatic test_held_done();
    int c, bad, hi;
    logic [3:0][6:0] obs;
    test_directed(16384);
    @(negedge clk);
    product = 16'hFFFF;
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) hi++;
    end
    n_checks++; if (hi !== 0) $display("FAIL held_done_busy got %0d want 0", hi); else n_pass++;
    observe(1'b0, obs, bad);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs[k] !== exp_seg(k, 1'b0, 1'b0, 16384))
        $display("FAIL held_done_digit idx=%0d got %b want %b", k, obs[k], exp_seg(k, 1'b0, 1'b0, 16384));
      else n_pass++;
    end
    test_directed(-1);
  endtask

  task automatic test_back_to_back(input int v, input int v2);
    int c, bad;
    logic [3:0][6:0] obs;
    start_conv(v);
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) c++;
      else break;
      if (i == 2) done = 1'b0;
      if (i == 4) begin
        done = 1'b1;
        product = 16'(v2);
      end
    end
    set_model(v);
    n_checks++; if (c !== 16) $display("FAIL b2b_busy_len got %0d want 16", c); else n_pass++;
    count_busy(c);
    n_checks++; if (c !== 0) $display("FAIL b2b_no_restart got %0d want 0", c); else n_pass++;
    observe(1'b0, obs, bad);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs[k] !== exp_seg(k, 1'b0, model_neg, model_mag))
        $display("FAIL b2b_digit idx=%0d got %b want %b", k, obs[k], exp_seg(k, 1'b0, model_neg, model_mag));
      else n_pass++;
    end
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    logic [3:0][6:0] obs;
    start_conv(12321);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) begin
        rst_n = 1'b0;
        done = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (an !== 4'b1110) $display("FAIL mid_reset_an got %b want 1110", an); else n_pass++;
    n_checks++; if (seg !== 7'b1000000) $display("FAIL mid_reset_seg got %b want 1000000", seg); else n_pass++;
    rst_n = 1'b1;
    set_model(0);
    observe(1'b0, obs, bad);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs[k] !== exp_seg(k, 1'b0, 1'b0, 0))
        $display("FAIL mid_reset_digit idx=%0d got %b want %b", k, obs[k], exp_seg(k, 1'b0, 1'b0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_powerup_done_high();
    int hi;
    @(negedge clk);
    rst_n = 1'b0;
    done = 1'b1;
    product = 16'd777;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_model(0);
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) hi++;
    end
    n_checks++; if (hi !== 0) $display("FAIL powerup_done_busy got %0d want 0", hi); else n_pass++;
    test_directed(777);
  endtask

  task automatic test_random();
    int v;
    test_directed(-32768);
    test_directed(0);
    test_directed(32767);
    for (int n = 0; n < 8; n++) begin
      v = int'($signed(16'($urandom_range(0, 65535))));
      test_directed(v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed(12321);
    test_directed(-16256);
    test_held_done();
    test_back_to_back(4321, -999);
    test_reset_mid();
    test_powerup_done_high();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
